// File: rtl/retry_pkg.sv
// retry_pkg: ID and sizing helpers shared by the retry start and end blocks
package retry_pkg;

   function automatic int retry_num_slots(input int id_size);
      return 1 << (id_size - 1);
   endfunction

   function automatic int retry_cnt_w(input int max_retries);
      return $clog2(max_retries + 1);
   endfunction

   // Builds {^idx, idx} for an ID of width w; upper bits stay zero
   function automatic logic [31:0] retry_make_id(input int w, input logic [31:0] idx);
      logic [31:0] r;
      logic        p;
      r = '0;
      p = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i < w - 1) begin
            r[i] = idx[i];
            p    = p ^ idx[i];
         end
      end
      r[w-1] = p;
      return r;
   endfunction

   // A well-formed ID has even parity across all w bits
   function automatic logic retry_id_parity_ok(input int w, input logic [31:0] id);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) p = p ^ id[i];
      end
      return ~p;
   endfunction

endpackage

// File: rtl/lzc.sv
// lzc: leading/trailing zero counter, MODE 0 counts trailing zeros
module lzc #(
   parameter int WIDTH     = 2,
   parameter bit MODE      = 1'b0,
   parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   // Scan so that the bit nearest the counted end is visited last and wins
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in_i[MODE ? i : WIDTH-1-i]) cnt_o = MODE ? CNT_WIDTH'(WIDTH-1-i) : CNT_WIDTH'(WIDTH-1-i);
      end
   end

   assign empty_o = ~|in_i;

endmodule

// File: rtl/retry_start_tracked.sv
// retry_start_tracked: tags transfers with parity IDs, holds them in slots and re-issues retries
module retry_start_tracked
   import retry_pkg::*;
#(
   parameter type         DataType   = logic,
   parameter int unsigned IDSize     = 3,
   parameter int unsigned MaxRetries = 2,
   localparam int unsigned NumSlots  = retry_num_slots(IDSize),
   localparam int unsigned InfW      = $clog2(NumSlots + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  DataType           data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output DataType           data_o,
   output logic [IDSize-1:0] id_o,
   output logic              valid_o,
   input  logic              ready_i,
   input  logic [IDSize-1:0] retry_id_i,
   input  logic              retry_valid_i,
   output logic              retry_ready_o,
   input  logic [IDSize-1:0] release_id_i,
   input  logic              release_valid_i,
   output logic              error_valid_o,
   output logic [IDSize-1:0] error_id_o,
   output logic              parity_error_o,
   output logic [InfW-1:0]   inflight_o
);

   localparam int unsigned CntW = retry_cnt_w(MaxRetries);
   localparam int unsigned IdxW = IDSize - 1;

   logic [NumSlots-1:0] busy_q, busy_d, free_vec;
   DataType             data_q [NumSlots];
   DataType             data_d [NumSlots];
   logic [CntW-1:0]     cnt_q  [NumSlots];
   logic [CntW-1:0]     cnt_d  [NumSlots];
   logic                pend_valid_q, pend_valid_d;
   logic [IdxW-1:0]     pend_idx_q, pend_idx_d;
   logic                err_valid_q, err_valid_d;
   logic [IDSize-1:0]   err_id_q, err_id_d;
   logic                par_err_q, par_err_d;
   logic [IdxW-1:0]     alloc_idx, retry_idx, rel_idx;
   logic                alloc_empty, any_free, hs, retry_acc, retry_par_ok, rel_par_ok, rel_ok;

   // The pending slot is offered as free so a retry can always reuse its own storage
   assign free_vec = ~busy_q | (NumSlots'(pend_valid_q) << pend_idx_q);

   lzc #(.WIDTH(NumSlots), .MODE(1'b0), .CNT_WIDTH(IdxW)) i_lzc (
      .in_i   (free_vec),
      .cnt_o  (alloc_idx),
      .empty_o(alloc_empty)
   );

   assign any_free      = ~alloc_empty;
   assign valid_o       = pend_valid_q | (valid_i & any_free);
   assign data_o        = pend_valid_q ? data_q[pend_idx_q] : (valid_o ? data_i : '0);
   assign id_o          = IDSize'(retry_make_id(IDSize, 32'(alloc_idx)));
   assign ready_o       = ready_i & ~pend_valid_q & any_free;
   assign retry_ready_o = ~pend_valid_q | ready_i;
   assign hs            = valid_o & ready_i;
   assign retry_acc     = retry_valid_i & retry_ready_o;
   assign retry_idx     = retry_id_i[IdxW-1:0];
   assign rel_idx       = release_id_i[IdxW-1:0];
   assign retry_par_ok  = retry_id_parity_ok(IDSize, 32'(retry_id_i));
   assign rel_par_ok    = retry_id_parity_ok(IDSize, 32'(release_id_i));
   assign rel_ok        = release_valid_i & rel_par_ok & busy_q[rel_idx] &
                          ~(retry_acc & retry_par_ok & (retry_idx == rel_idx));
   assign error_valid_o  = err_valid_q;
   assign error_id_o     = err_id_q;
   assign parity_error_o = par_err_q;

   // Frees are applied first so an allocation in the same cycle always takes effect
   always_comb begin
      busy_d       = busy_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      pend_valid_d = pend_valid_q & ~hs;
      pend_idx_d   = pend_idx_q;
      err_valid_d  = 1'b0;
      err_id_d     = err_id_q;
      par_err_d    = release_valid_i & ~rel_par_ok;
      if (rel_ok) busy_d[rel_idx] = 1'b0;
      if (retry_acc & ~retry_par_ok) par_err_d = 1'b1;
      if (retry_acc & retry_par_ok & busy_q[retry_idx]) begin
         if (cnt_q[retry_idx] == CntW'(MaxRetries)) begin
            busy_d[retry_idx] = 1'b0;
            err_valid_d       = 1'b1;
            err_id_d          = retry_id_i;
         end else begin
            pend_valid_d = 1'b1;
            pend_idx_d   = retry_idx;
         end
      end
      if (hs & pend_valid_q & (alloc_idx != pend_idx_q)) busy_d[pend_idx_q] = 1'b0;
      if (hs) begin
         busy_d[alloc_idx] = 1'b1;
         data_d[alloc_idx] = data_o;
         cnt_d[alloc_idx]  = pend_valid_q ? cnt_q[pend_idx_q] + CntW'(1) : '0;
      end
   end

   // Slot storage, pending retry and error pulses; reset drops everything silently
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q       <= '0;
         pend_valid_q <= 1'b0;
         pend_idx_q   <= '0;
         err_valid_q  <= 1'b0;
         err_id_q     <= '0;
         par_err_q    <= 1'b0;
         for (int i = 0; i < NumSlots; i++) begin
            data_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         busy_q       <= busy_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_idx_q   <= pend_idx_d;
         err_valid_q  <= err_valid_d;
         err_id_q     <= err_id_d;
         par_err_q    <= par_err_d;
      end
   end

   // Occupied-slot count
   always_comb begin
      inflight_o = '0;
      for (int i = 0; i < NumSlots; i++) inflight_o = inflight_o + InfW'(busy_q[i]);
   end

endmodule
